// File: rtl/instr_fetch.sv
// Instruction fetch unit: 2-credit request/response pipeline with redirect flush.
// Optional fetch_count performance counter when INSTR_FETCH_PERF_CNT_EN is defined.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    logic [29:0] pc_q;
    logic [1:0]  outst_q;
    logic [1:0]  drop_q;
    logic [1:0]  fifo_cnt_q;
    logic        aq_rd_q, aq_wr_q;
    logic        fq_rd_q, fq_wr_q;
    logic [29:0] aq_mem   [2];
    logic [29:0] fq_pc    [2];
    logic [31:0] fq_instr [2];

    logic [2:0] credit;
    logic       req_fire;
    logic       rsp_pop;
    logic       rsp_keep;
    logic       out_fire;

    assign credit   = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_fire  = out_valid & out_ready;

    // A slot freed by this cycle's pop is reusable immediately; otherwise
    // a 1-cycle memory would only sustain one instruction every two cycles.
    assign imem_req_valid = rst_n & ~redirect_valid &
                            ((credit < 3'd2) | ((credit == 3'd2) & out_fire));
    assign imem_req_addr  = {pc_q, 2'b00};
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Responses with nothing outstanding are ignored so the counters cannot wrap.
    assign rsp_pop  = imem_rsp_valid & (outst_q != 2'd0);
    assign rsp_keep = rsp_pop & (drop_q == 2'd0) & ~redirect_valid;

    assign out_instr = out_valid ? fq_instr[fq_rd_q] : 32'd0;
    assign out_pc    = out_valid ? {fq_pc[fq_rd_q], 2'b00} : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC[31:2];
            outst_q    <= 2'd0;
            drop_q     <= 2'd0;
            aq_rd_q    <= 1'b0;
            aq_wr_q    <= 1'b0;
            fifo_cnt_q <= 2'd0;
            fq_rd_q    <= 1'b0;
            fq_wr_q    <= 1'b0;
        end else begin
            if (redirect_valid)
                pc_q <= redirect_pc[31:2];
            else if (req_fire)
                pc_q <= pc_q + 30'd1;

            outst_q <= outst_q + 2'(req_fire) - 2'(rsp_pop);
            if (req_fire) aq_wr_q <= ~aq_wr_q;
            if (rsp_pop)  aq_rd_q <= ~aq_rd_q;

            // Everything still in flight after this cycle belongs to the old path.
            if (redirect_valid)
                drop_q <= outst_q - 2'(rsp_pop);
            else if (rsp_pop && drop_q != 2'd0)
                drop_q <= drop_q - 2'd1;

            if (redirect_valid) begin
                fifo_cnt_q <= 2'd0;
                fq_rd_q    <= fq_wr_q;
            end else begin
                fifo_cnt_q <= fifo_cnt_q + 2'(rsp_keep) - 2'(out_fire);
                if (rsp_keep) fq_wr_q <= ~fq_wr_q;
                if (out_fire) fq_rd_q <= ~fq_rd_q;
            end
        end
    end

    // NOTE: queue storage carries no reset; the counters gate every read, and
    // the outputs are forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (req_fire)
            aq_mem[aq_wr_q] <= pc_q;
        if (rsp_keep) begin
            fq_pc[fq_wr_q]    <= aq_mem[aq_rd_q];
            fq_instr[fq_wr_q] <= imem_rsp_data;
        end
    end

`ifdef INSTR_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_count <= 32'd0;
        else if (out_fire)
            fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios, memory model, decoupled output monitor.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef INSTR_FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend[$];
    exp_t  mon_e;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    lat = 1;
    logic  rsp_legal = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back('{pc, mem_word(pc)});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start();
        @(negedge clk);
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        lat            = 1;
        check("sb_drained", exp_q.size(), 32'd0);
        cycles(2);
    endtask

    // Pops exactly n instructions: out_ready is high on n consecutive cycles.
    task automatic drain(input int n);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    // Memory model: in-order responses 'lat' cycles after acceptance.
    always @(negedge clk) begin
        #2;
        imem_rsp_valid = 1'b0;
        rsp_legal      = 1'b0;
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                rsp_legal      = 1'b1;
                void'(pend.pop_front());
            end
            if (imem_req_valid && imem_req_ready)
                pend.push_back('{imem_req_addr, cyc + lat});
        end
    end

    always @(posedge clk) begin
        if (rst_n && imem_rsp_valid && !rsp_legal) begin
            checks++;
            errors++;
            $display("FAIL illegal_rsp: response with no outstanding request (t=%0t)", $time);
        end
    end

    // Output monitor: compares every accepted instruction with the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got out_pc 0x%08h, expected no instruction", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_pc", out_pc, mon_e.pc);
                check("sb_instr", out_instr, mon_e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int found;

        // Reset values
        @(negedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);

        // Streaming at one instruction per cycle
        start();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) expect_pc(32'(i * 4));
        #1;
        check("t1_req_valid_a", imem_req_valid, 32'd1);
        check("t1_addr_a", imem_req_addr, 32'h0);
        @(negedge clk); #1;
        check("t1_req_valid_b", imem_req_valid, 32'd1);
        check("t1_addr_b", imem_req_addr, 32'h4);
        @(negedge clk); #1;
        check("t1_req_valid_c", imem_req_valid, 32'd1);
        check("t1_addr_c", imem_req_addr, 32'h8);
        check("t1_out_valid_a", out_valid, 32'd1);
        @(negedge clk); #1;
        check("t1_out_valid_b", out_valid, 32'd1);
        @(negedge clk); #1;
        check("t1_out_valid_c", out_valid, 32'd1);
        cycles(2);
        @(negedge clk);
        out_ready = 1'b0;
        cycles(2);

        // Backpressure: two buffered, fetch stalls, then resumes
        start();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(6);
        #1;
        check("t2_out_valid", out_valid, 32'd1);
        check("t2_req_stalled", imem_req_valid, 32'd0);
        check("t2_head_pc", out_pc, 32'h0);
        for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("t2_resume_valid", imem_req_valid, 32'd1);
        check("t2_resume_addr", imem_req_addr, 32'h8);
        cycles(3);
        @(negedge clk);
        out_ready = 1'b0;
        cycles(2);

        // Redirect with two requests outstanding
        start();
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        #1;
        check("t3_no_req_redirect", imem_req_valid, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        lat = 4;
        #1;
        check("t3_addr_10", imem_req_addr, 32'h10);
        @(negedge clk); #1;
        check("t3_addr_14", imem_req_addr, 32'h14);
        @(negedge clk); #1;
        check("t3_credit_full", imem_req_valid, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        lat = 1;
        expect_pc(32'h100);
        expect_pc(32'h104);
        @(negedge clk);
        redirect_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (imem_req_valid) begin
                found = 1;
                break;
            end
        end
        check("t3_req_seen", 32'(found), 32'd1);
        check("t3_addr_100", imem_req_addr, 32'h100);
        cycles(8); #1;
        check("t3_buffered", out_valid, 32'd1);
        drain(2);
        cycles(2);

        // Response arriving in the redirect cycle is discarded
        start();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t4_addr_0", imem_req_addr, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        expect_pc(32'h40);
        expect_pc(32'h44);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("t4_req_valid", imem_req_valid, 32'd1);
        check("t4_addr_40", imem_req_addr, 32'h40);
        cycles(6); #1;
        check("t4_buffered", out_valid, 32'd1);
        drain(2);
        cycles(2);

        // Back-to-back redirects: last target wins
        start();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect_pc = 32'h83;
        expect_pc(32'h80);
        expect_pc(32'h84);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("t5_addr_80", imem_req_addr, 32'h80);
        cycles(6);
        drain(2);
        cycles(2);

        // Memory not ready: request held with stable address
        start();
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b0;
        #1;
        check("t6_hold_valid", imem_req_valid, 32'd1);
        check("t6_hold_addr", imem_req_addr, 32'h0);
        repeat (4) begin
            @(negedge clk); #1;
            check("t6_hold_valid", imem_req_valid, 32'd1);
            check("t6_hold_addr", imem_req_addr, 32'h0);
        end
        @(negedge clk);
        imem_req_ready = 1'b1;
        #1;
        check("t6_accept_addr", imem_req_addr, 32'h0);
        @(negedge clk); #1;
        check("t6_next_addr", imem_req_addr, 32'h4);
        cycles(2);

        // Reset mid-operation with a full FIFO
        start();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(6); #1;
        check("t7_full", out_valid, 32'd1);
        check("t7_stalled", imem_req_valid, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_out_valid", out_valid, 32'd0);
        check("t7_rst_out_pc", out_pc, 32'd0);
        check("t7_rst_out_instr", out_instr, 32'd0);
        check("t7_rst_req_valid", imem_req_valid, 32'd0);
        check("t7_rst_addr", imem_req_addr, RESET_PC);
        cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t7_first_valid", imem_req_valid, 32'd1);
        check("t7_first_addr", imem_req_addr, RESET_PC);
        expect_pc(RESET_PC);
        expect_pc(RESET_PC + 32'h4);
        cycles(6);
        drain(2);
        cycles(2);

`ifdef INSTR_FETCH_PERF_CNT_EN
        // Performance counter across a redirect
        start();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t8_count_rst", fetch_count, 32'd0);
        for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
        cycles(6);
        drain(4);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) expect_pc(32'h500 + 32'(i * 4));
        cycles(8);
        drain(6);
        @(negedge clk); #1;
        check("t8_count", fetch_count, 32'd10);
`endif

        cycles(3);
        check("sb_final_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
